// File: rtl/torreta_pkg.sv
// Shared definitions for the turret control unit: state codes and default watchdog length.
// The state codes are also the values driven on db_estado.
package torreta_pkg;

   typedef enum logic [3:0] {
      INICIAL        = 4'h0,
      PREPARACAO     = 4'h1,
      MEDIR          = 4'h2,
      AGUARDA_MEDIDA = 4'h3,
      TRANSMITIR     = 4'h4,
      AGUARDA_TX     = 4'h5,
      DECIDE         = 4'h6,
      ESPERA         = 4'h7,
      GIRAR          = 4'h8,
      ARMAR          = 4'h9,
      DISPARAR       = 4'hA,
      RECARREGAR     = 4'hB
   } estado_t;

   // 30 ms at 50 MHz
   localparam int TIMEOUT_CICLOS_PADRAO = 1_500_000;
   localparam int N_TIMEOUT_PADRAO      = 21;

   // True for the three states of the engagement sequence, which only reset can abort.
   function automatic logic em_engajamento(input estado_t e);
      return (e == ARMAR) || (e == DISPARAR) || (e == RECARREGAR);
   endfunction

endpackage

// File: rtl/contador_m.sv
// Modulo-M up counter with synchronous clear; fim flags the terminal count M-1.
// Used as the measurement watchdog of torreta_uc.
module contador_m #(
   parameter int M = 100,
   parameter int N = 7
) (
   input  logic clock,
   input  logic reset,
   input  logic zera_s,
   input  logic conta,
   output logic fim
);

   localparam logic [N-1:0] ULTIMO = N'(M - 1);

   logic [N-1:0] valor;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valor <= '0;
      end else if (zera_s) begin
         valor <= '0;
      end else if (conta) begin
         if (valor == ULTIMO) valor <= '0;
         else                 valor <= valor + 1'b1;
      end
   end

   assign fim = (valor == ULTIMO);

endmodule

// File: rtl/torreta_uc.sv
// Turret control unit: Moore FSM sequencing scan and engagement cycles of torreta_fd,
// with a watchdog that abandons a measurement whose echo never arrives.
module torreta_uc
   import torreta_pkg::*;
#(
   parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO,
   parameter int N_TIMEOUT      = N_TIMEOUT_PADRAO
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ligar,
   input  logic       medida_pronto,
   input  logic       envio_pronto,
   input  logic       fim_tempo,
   input  logic       ameaca_detectada,
   input  logic       municao_carregada,
   input  logic       disparo_pronto,
   input  logic       fim_disparo,
   input  logic       disparo_carregado,
   output logic       medir,
   output logic       transmitir,
   output logic       girar,
   output logic       conta_tempo,
   output logic       armar_disparo,
   output logic       disparar,
   output logic       recarregar_disparo,
   output logic       timeout_medida,
   output logic [3:0] db_estado
);

   estado_t estado;
   estado_t proximo;
   logic    fim_watchdog;
   logic    expira;

   // Watchdog runs only while waiting for an echo and is cleared everywhere else.
   contador_m #(
      .M(TIMEOUT_CICLOS),
      .N(N_TIMEOUT)
   ) u_watchdog (
      .clock (clock),
      .reset (reset),
      .zera_s(estado != AGUARDA_MEDIDA),
      .conta (1'b1),
      .fim   (fim_watchdog)
   );

   // An echo arriving in the expiry cycle still counts as a valid measurement.
   assign expira = (estado == AGUARDA_MEDIDA) && fim_watchdog && !medida_pronto;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) estado <= INICIAL;
      else        estado <= proximo;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) timeout_medida <= 1'b0;
      else        timeout_medida <= expira;
   end

   always_comb begin
      proximo = estado;
      case (estado)
         INICIAL:        if (ligar) proximo = PREPARACAO;
         PREPARACAO:     proximo = MEDIR;
         MEDIR:          proximo = AGUARDA_MEDIDA;
         AGUARDA_MEDIDA: begin
            if (medida_pronto)     proximo = TRANSMITIR;
            else if (fim_watchdog) proximo = ESPERA;
         end
         TRANSMITIR:     proximo = AGUARDA_TX;
         AGUARDA_TX:     if (envio_pronto) proximo = DECIDE;
         DECIDE: begin
            if (ameaca_detectada && municao_carregada) proximo = ARMAR;
            else                                       proximo = ESPERA;
         end
         // Turning off wins over the rotation timer.
         ESPERA: begin
            if (!ligar)         proximo = INICIAL;
            else if (fim_tempo) proximo = GIRAR;
         end
         GIRAR:          proximo = MEDIR;
         ARMAR:          if (disparo_pronto)    proximo = DISPARAR;
         DISPARAR:       if (fim_disparo)       proximo = RECARREGAR;
         RECARREGAR:     if (disparo_carregado) proximo = ESPERA;
         default:        proximo = INICIAL;
      endcase
   end

   always_comb begin
      medir              = 1'b0;
      transmitir         = 1'b0;
      girar              = 1'b0;
      conta_tempo        = 1'b0;
      armar_disparo      = 1'b0;
      disparar           = 1'b0;
      recarregar_disparo = 1'b0;
      case (estado)
         MEDIR:      medir              = 1'b1;
         TRANSMITIR: transmitir         = 1'b1;
         GIRAR:      girar              = 1'b1;
         ESPERA:     conta_tempo        = 1'b1;
         ARMAR:      armar_disparo      = 1'b1;
         DISPARAR:   disparar           = 1'b1;
         RECARREGAR: recarregar_disparo = 1'b1;
         default: ;
      endcase
   end

   assign db_estado = estado;

endmodule

// File: tb/tb_torreta_uc.sv
// Randomized bench for torreta_uc: builds an expected per-cycle trace from scan/engagement
// scenarios, plays the datapath role with noise on irrelevant inputs, and compares every cycle.
module tb_torreta_uc;

   localparam int TO = 100;

   localparam logic [3:0] S_INI = 4'h0, S_PRE = 4'h1, S_MED = 4'h2, S_AGM = 4'h3,
                          S_TX  = 4'h4, S_AGT = 4'h5, S_DEC = 4'h6, S_ESP = 4'h7,
                          S_GIR = 4'h8, S_ARM = 4'h9, S_DIS = 4'hA, S_REC = 4'hB;

   // Input bit positions: {dc, fd, dp, mc, am, ft, ep, mp, ligar}
   localparam logic [8:0] L  = 9'h001, MP = 9'h002, EP = 9'h004, FT = 9'h008, AM = 9'h010,
                          MC = 9'h020, DP = 9'h040, FD = 9'h080, DC = 9'h100, NONE = 9'h000;

   typedef struct packed {
      logic [3:0] st;
      logic [8:0] in;
      logic       to;
   } cyc_t;

   logic clock = 1'b0;
   logic reset;
   logic ligar, medida_pronto, envio_pronto, fim_tempo, ameaca_detectada, municao_carregada;
   logic disparo_pronto, fim_disparo, disparo_carregado;
   logic medir, transmitir, girar, conta_tempo, armar_disparo, disparar, recarregar_disparo;
   logic timeout_medida;
   logic [3:0] db_estado;

   cyc_t exp_q[$];
   int n_checks = 0;
   int n_errors = 0;

   torreta_uc #(.TIMEOUT_CICLOS(TO), .N_TIMEOUT(7)) dut (
      .clock(clock), .reset(reset), .ligar(ligar),
      .medida_pronto(medida_pronto), .envio_pronto(envio_pronto), .fim_tempo(fim_tempo),
      .ameaca_detectada(ameaca_detectada), .municao_carregada(municao_carregada),
      .disparo_pronto(disparo_pronto), .fim_disparo(fim_disparo),
      .disparo_carregado(disparo_carregado),
      .medir(medir), .transmitir(transmitir), .girar(girar), .conta_tempo(conta_tempo),
      .armar_disparo(armar_disparo), .disparar(disparar),
      .recarregar_disparo(recarregar_disparo), .timeout_medida(timeout_medida),
      .db_estado(db_estado)
   );

   // clock / reset
   always #5 clock = ~clock;

   initial begin
      #5ms;
      $display("FAIL sim_timeout simulation exceeded its time budget");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Command outputs expected for a state: {medir, transmitir, girar, conta, armar, disparar, recarregar}
   function automatic logic [6:0] exp_out(input logic [3:0] st);
      case (st)
         S_MED:   return 7'b1000000;
         S_TX:    return 7'b0100000;
         S_GIR:   return 7'b0010000;
         S_ESP:   return 7'b0001000;
         S_ARM:   return 7'b0000100;
         S_DIS:   return 7'b0000010;
         S_REC:   return 7'b0000001;
         default: return 7'b0000000;
      endcase
   endfunction

   function automatic logic [6:0] outs();
      return {medir, transmitir, girar, conta_tempo, armar_disparo, disparar, recarregar_disparo};
   endfunction

   // One expected cycle: inputs outside the mask are random noise the DUT must ignore.
   function automatic void add(input logic [3:0] st, input logic [8:0] m, input logic [8:0] v,
                               input logic to);
      logic [8:0] r;
      r = 9'($urandom_range(0, 511));
      exp_q.push_back('{st: st, in: (r & ~m) | (v & m), to: to});
   endfunction

   // One scan round starting in MEDIR; dm = 0 means the echo never arrives.
   task automatic gen_round(input int dm, input int dt, input bit thr, input bit ammo,
                            input int da, input int df, input int dr, input int de,
                            input bit stop, input int idle);
      logic [8:0] lk;
      logic       to_flag;
      lk      = stop ? L : NONE;
      to_flag = (dm == 0);
      add(S_MED, NONE, NONE, 1'b0);
      if (dm == 0) begin
         for (int i = 0; i < TO; i++) add(S_AGM, MP, NONE, 1'b0);
      end else begin
         for (int i = 0; i < dm; i++) add(S_AGM, MP, (i == dm - 1) ? MP : NONE, 1'b0);
         add(S_TX, NONE, NONE, 1'b0);
         for (int i = 0; i < dt; i++) add(S_AGT, EP, (i == dt - 1) ? EP : NONE, 1'b0);
         add(S_DEC, AM | MC, (thr ? AM : NONE) | (ammo ? MC : NONE), 1'b0);
         if (thr && ammo) begin
            for (int i = 0; i < da; i++) add(S_ARM, DP | lk, (i == da - 1) ? DP : NONE, 1'b0);
            for (int i = 0; i < df; i++) add(S_DIS, FD | lk, (i == df - 1) ? FD : NONE, 1'b0);
            for (int i = 0; i < dr; i++) add(S_REC, DC | lk, (i == dr - 1) ? DC : NONE, 1'b0);
         end
      end
      if (stop) begin
         add(S_ESP, L | FT, FT, to_flag);
         for (int i = 0; i < idle; i++) add(S_INI, L, NONE, 1'b0);
         add(S_INI, L, L, 1'b0);
         add(S_PRE, NONE, NONE, 1'b0);
      end else begin
         for (int i = 0; i < de; i++)
            add(S_ESP, L | FT, L | ((i == de - 1) ? FT : NONE), (i == 0) ? to_flag : 1'b0);
         add(S_GIR, NONE, NONE, 1'b0);
      end
   endtask

   // driver: play the expected trace cycle by cycle, checking just after each rising edge
   task automatic run_queue();
      cyc_t e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("estado", 32'(db_estado), 32'(e.st));
         check("saidas", 32'(outs()), 32'(exp_out(e.st)));
         check("timeout", 32'(timeout_medida), 32'(e.to));
         {disparo_carregado, fim_disparo, disparo_pronto, municao_carregada, ameaca_detectada,
          fim_tempo, envio_pronto, medida_pronto, ligar} = e.in;
         @(posedge clock);
         #1;
      end
   endtask

   initial begin
      reset = 1'b0;
      {disparo_carregado, fim_disparo, disparo_pronto, municao_carregada, ameaca_detectada,
       fim_tempo, envio_pronto, medida_pronto, ligar} = '0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_estado", 32'(db_estado), 32'(S_INI));
      check("rst_saidas", 32'(outs()), 32'd0);
      check("rst_timeout", 32'(timeout_medida), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;

      for (int i = 0; i < 3; i++) add(S_INI, L, NONE, 1'b0);
      add(S_INI, L, L, 1'b0);
      add(S_PRE, NONE, NONE, 1'b0);
      gen_round(10, 50, 1'b0, 1'b1, 1, 1, 1, 4, 1'b0, 0);  // no threat
      gen_round(5, 3, 1'b1, 1'b1, 3, 4, 2, 3, 1'b0, 0);    // engagement
      gen_round(4, 2, 1'b1, 1'b0, 1, 1, 1, 2, 1'b0, 0);    // no ammunition
      gen_round(0, 1, 1'b0, 1'b0, 1, 1, 1, 3, 1'b0, 0);    // watchdog expiry
      gen_round(TO, 2, 1'b0, 1'b0, 1, 1, 1, 2, 1'b0, 0);   // echo in the expiry cycle
      gen_round(3, 2, 1'b0, 1'b0, 1, 1, 1, 1, 1'b1, 3);    // stop in ESPERA
      gen_round(3, 2, 1'b1, 1'b1, 2, 5, 2, 1, 1'b1, 2);    // stop while firing
      run_queue();

      for (int r = 0; r < 25; r++) begin
         int dm;
         case ($urandom_range(0, 7))
            0:       dm = 0;
            1:       dm = TO;
            default: dm = int'($urandom_range(1, 15));
         endcase
         gen_round(dm, int'($urandom_range(1, 8)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), int'($urandom_range(1, 5)),
                   int'($urandom_range(1, 5)), int'($urandom_range(1, 5)),
                   int'($urandom_range(1, 6)), ($urandom_range(0, 4) == 0),
                   int'($urandom_range(1, 4)));
         run_queue();
      end

      // Drive into ARMAR and hold there, then hit reset mid-cycle.
      add(S_MED, NONE, NONE, 1'b0);
      add(S_AGM, MP, NONE, 1'b0);
      add(S_AGM, MP, MP, 1'b0);
      add(S_TX, NONE, NONE, 1'b0);
      add(S_AGT, EP, EP, 1'b0);
      add(S_DEC, AM | MC, AM | MC, 1'b0);
      for (int i = 0; i < 4; i++) add(S_ARM, DP | L, NONE, 1'b0);
      run_queue();
      check("pre_reset", 32'(db_estado), 32'(S_ARM));
      #2;
      reset = 1'b0;
      #1;
      check("mid_rst_estado", 32'(db_estado), 32'(S_INI));
      check("mid_rst_saidas", 32'(outs()), 32'd0);
      check("mid_rst_timeout", 32'(timeout_medida), 32'd0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      check("post_rst_estado", 32'(db_estado), 32'(S_INI));
      check("post_rst_saidas", 32'(outs()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
